// File: rtl/gfx_blender_multi.sv
// Per-pixel blender: replace / alpha / saturating add / multiply over CH channels of CW bits.
// Reads the target pixel only when the blend result depends on it; transparent alpha fragments are dropped.
`timescale 1ns/1ps
module gfx_blender_multi #(
  parameter int PW  = 16,
  parameter int CW  = 8,
  parameter int CH  = 3,
  parameter int BPP = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       mode_i,
  input  logic [31:0]      target_base_i,
  input  logic [PW-1:0]    target_size_x_i,
  input  logic [7:0]       global_alpha_i,
  input  logic [PW-1:0]    x_i,
  input  logic [PW-1:0]    y_i,
  input  logic [PW-1:0]    z_i,
  input  logic [7:0]       alpha_i,
  input  logic [CH*CW-1:0] color_i,
  input  logic             write_i,
  output logic             ack_o,
  output logic             target_request_o,
  output logic [31:0]      target_addr_o,
  input  logic [CH*CW-1:0] target_data_i,
  input  logic             target_ack_i,
  input  logic             wbm_busy_i,
  output logic [PW-1:0]    pixel_x_o,
  output logic [PW-1:0]    pixel_y_o,
  output logic [PW-1:0]    pixel_z_o,
  output logic [CH*CW-1:0] pixel_color_o,
  output logic             write_o,
  input  logic             ack_i
);

  localparam int CD = CH * CW;
  localparam int MW = (2 * CW + 1 > CW + 9) ? 2 * CW + 1 : CW + 9;
  localparam int AW = 2 * PW + 8;

  localparam logic [1:0] M_REPLACE = 2'd0;
  localparam logic [1:0] M_ALPHA   = 2'd1;
  localparam logic [1:0] M_ADD     = 2'd2;
  localparam logic [1:0] M_MUL     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_ALPHA, S_READ, S_BLEND, S_WRITE, S_WACK, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]    mode_reg;
  logic [PW-1:0] x_reg, y_reg, z_reg;
  logic [CD-1:0] src_reg, dst_reg;
  logic [15:0]   p_reg;
  logic [8:0]    a_prime_reg;

  logic [7:0]    a_calc;
  logic [8:0]    inv_alpha;
  logic [AW-1:0] pix_offset;
  logic [CD-1:0] blend_color;

  // Rounded divide-by-255 of the alpha product, so 255*255 maps to 255 and 0 to 0.
  assign a_calc     = 8'((17'(p_reg) + 17'(p_reg[15:8]) + 17'd128) >> 8);
  assign inv_alpha  = 9'd256 - a_prime_reg;
  assign pix_offset = AW'(y_reg) * AW'(target_size_x_i) + AW'(x_reg);

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [CW-1:0] s_ch, d_ch, alpha_res, add_term, add_res, mul_res;
    logic [CW:0]   add_sum, s_prime;
    logic [MW-1:0] sa_prod;

    assign s_ch      = src_reg[gi*CW +: CW];
    assign d_ch      = dst_reg[gi*CW +: CW];
    assign sa_prod   = MW'(s_ch) * MW'(a_prime_reg);
    assign alpha_res = CW'((sa_prod + MW'(d_ch) * MW'(inv_alpha) + MW'(128)) >> 8);
    assign add_term  = CW'((sa_prod + MW'(128)) >> 8);
    assign add_sum   = {1'b0, d_ch} + {1'b0, add_term};
    assign add_res   = add_sum[CW] ? {CW{1'b1}} : add_sum[CW-1:0];
    // Full-scale source maps to 2^CW so that multiplying by white is an identity.
    assign s_prime   = {1'b0, s_ch} + (CW+1)'(s_ch[CW-1]);
    assign mul_res   = CW'((MW'(s_prime) * MW'(d_ch) + MW'(1 << (CW - 1))) >> CW);

    assign blend_color[gi*CW +: CW] = (mode_reg == M_ALPHA) ? alpha_res :
                                      (mode_reg == M_ADD)   ? add_res   :
                                      (mode_reg == M_MUL)   ? mul_res   : s_ch;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (write_i && !ack_o) state_next = S_ALPHA;
      S_ALPHA: begin
        if (mode_reg == M_ALPHA && a_calc == 8'd0)
          state_next = S_DONE;
        else if (mode_reg == M_REPLACE || (mode_reg == M_ALPHA && a_calc == 8'd255))
          state_next = S_WRITE;
        else
          state_next = S_READ;
      end
      S_READ:  if (target_ack_i) state_next = S_BLEND;
      S_BLEND: state_next = S_WRITE;
      S_WRITE: state_next = S_WACK;
      S_WACK:  if (ack_i) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= S_IDLE;
      mode_reg         <= '0;
      x_reg            <= '0;
      y_reg            <= '0;
      z_reg            <= '0;
      src_reg          <= '0;
      dst_reg          <= '0;
      p_reg            <= '0;
      a_prime_reg      <= '0;
      ack_o            <= 1'b0;
      target_request_o <= 1'b0;
      target_addr_o    <= '0;
      pixel_x_o        <= '0;
      pixel_y_o        <= '0;
      pixel_z_o        <= '0;
      pixel_color_o    <= '0;
      write_o          <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_o     <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (write_i && !ack_o) begin
            mode_reg <= mode_i;
            x_reg    <= x_i;
            y_reg    <= y_i;
            z_reg    <= z_i;
            src_reg  <= color_i;
            p_reg    <= 16'(alpha_i) * 16'(global_alpha_i);
          end
        end
        S_ALPHA: begin
          a_prime_reg   <= 9'(a_calc) + 9'(a_calc[7]);
          target_addr_o <= target_base_i + 32'(pix_offset * AW'(BPP));
          if (state_next == S_WRITE) pixel_color_o <= src_reg;
        end
        S_READ: begin
          if (target_ack_i) begin
            target_request_o <= 1'b0;
            dst_reg          <= target_data_i;
          end else begin
            target_request_o <= !wbm_busy_i | target_request_o;
          end
        end
        S_BLEND: pixel_color_o <= blend_color;
        S_WRITE: begin
          pixel_x_o <= x_reg;
          pixel_y_o <= y_reg;
          pixel_z_o <= z_reg;
          write_o   <= 1'b1;
        end
        S_WACK:  write_o <= 1'b0;
        S_DONE:  ack_o   <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_blender_multi.sv
// Directed bench for gfx_blender_multi: each task drives one scenario and checks its observations inline.
`timescale 1ns/1ps
module tb_gfx_blender_multi;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  mode_i = '0;
  logic [31:0] target_base_i = 32'h1000_0000;
  logic [15:0] target_size_x_i = 16'd640;
  logic [7:0]  global_alpha_i = '0;
  logic [15:0] x_i = '0, y_i = '0, z_i = '0;
  logic [7:0]  alpha_i = '0;
  logic [23:0] color_i = '0;
  logic        write_i = 1'b0;
  logic        ack_o;
  logic        target_request_o;
  logic [31:0] target_addr_o;
  logic [23:0] target_data_i = '0;
  logic        target_ack_i = 1'b0;
  logic        wbm_busy_i = 1'b0;
  logic [15:0] pixel_x_o, pixel_y_o, pixel_z_o;
  logic [23:0] pixel_color_o;
  logic        write_o;
  logic        ack_i = 1'b0;

  gfx_blender_multi dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .target_base_i(target_base_i),
    .target_size_x_i(target_size_x_i), .global_alpha_i(global_alpha_i),
    .x_i(x_i), .y_i(y_i), .z_i(z_i), .alpha_i(alpha_i), .color_i(color_i),
    .write_i(write_i), .ack_o(ack_o), .target_request_o(target_request_o),
    .target_addr_o(target_addr_o), .target_data_i(target_data_i),
    .target_ack_i(target_ack_i), .wbm_busy_i(wbm_busy_i),
    .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
    .pixel_color_o(pixel_color_o), .write_o(write_o), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Observations from the last run_fragment; *_n are edges counted after the accepting edge.
  int r_reads, r_writes, r_acks, r_write_n, r_ack_n, r_req_rise_n;
  int r_req_busy, r_req_drop, r_req_after_ack;
  bit r_timeout;
  logic [23:0] r_color;
  logic [15:0] r_x, r_y, r_z;
  logic [31:0] r_addr;

  // Drives one fragment, plays the reader arbiter and the render stage, and records what it sees.
  task automatic run_fragment(input logic [1:0] m, input logic [7:0] al, input logic [7:0] ga,
                              input logic [23:0] col, input logic [15:0] px, input logic [15:0] py,
                              input logic [15:0] pz, input logic [23:0] td, input int busy_n,
                              input int ack_wait, input bit hold_extra);
    int n, req_cnt;
    bit acked_rd, hold_pending, fin;
    @(negedge clk_i);
    mode_i = m; alpha_i = al; global_alpha_i = ga; color_i = col;
    x_i = px; y_i = py; z_i = pz;
    wbm_busy_i = (busy_n > 0);
    write_i = 1'b1;
    r_reads = 0; r_writes = 0; r_acks = 0; r_write_n = -1; r_ack_n = -1; r_req_rise_n = -1;
    r_req_busy = 0; r_req_drop = 0; r_req_after_ack = 0; r_timeout = 1'b0;
    r_color = '0; r_x = '0; r_y = '0; r_z = '0; r_addr = '0;
    n = -1; req_cnt = 0; acked_rd = 1'b0; hold_pending = 1'b0; fin = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(posedge clk_i); #1;
      n++;
      if (target_ack_i) begin
        target_ack_i = 1'b0;
        r_reads++;
        acked_rd = 1'b1;
      end
      if (ack_i) ack_i = 1'b0;
      if (hold_pending) begin
        write_i = 1'b0;
        hold_pending = 1'b0;
      end
      if (target_request_o && wbm_busy_i) r_req_busy++;
      if (wbm_busy_i && n >= busy_n + 1) wbm_busy_i = 1'b0;
      if (target_request_o) begin
        if (acked_rd) r_req_after_ack++;
        else begin
          if (r_req_rise_n < 0) begin
            r_req_rise_n = n;
            r_addr = target_addr_o;
          end
          req_cnt++;
          if (req_cnt == ack_wait + 1) begin
            target_ack_i = 1'b1;
            target_data_i = td;
          end
        end
      end else if (r_req_rise_n >= 0 && !acked_rd) r_req_drop++;
      if (write_o) begin
        r_writes++;
        if (r_write_n < 0) begin
          r_write_n = n; r_color = pixel_color_o;
          r_x = pixel_x_o; r_y = pixel_y_o; r_z = pixel_z_o;
          ack_i = 1'b1;
        end
      end
      if (ack_o) begin
        r_acks++;
        if (r_ack_n < 0) begin
          r_ack_n = n;
          if (hold_extra) hold_pending = 1'b1;
          else write_i = 1'b0;
        end
      end
      if (r_ack_n >= 0 && n >= r_ack_n + 8) fin = 1'b1;
    end
    r_timeout = !fin;
    write_i = 1'b0; target_ack_i = 1'b0; ack_i = 1'b0; wbm_busy_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    tests++;
    if ({ack_o, target_request_o, write_o} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 000", {ack_o, target_request_o, write_o});
    end
    tests++;
    if (pixel_color_o !== 24'h0 || target_addr_o !== 32'h0) begin
      fails++; $display("FAIL reset_data: color %h addr %h want 0", pixel_color_o, target_addr_o);
    end
    tests++;
    if ({pixel_x_o, pixel_y_o, pixel_z_o} !== 48'h0) begin
      fails++; $display("FAIL reset_xyz: got %h want 0", {pixel_x_o, pixel_y_o, pixel_z_o});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_replace();
    run_fragment(2'd0, 8'd0, 8'h80, 24'h123456, 16'd3, 16'd2, 16'hFFFB, 24'h0, 0, 0, 1'b0);
    tests++;
    if (r_timeout) begin fails++; $display("FAIL replace_timeout: no ack_o within budget"); end
    tests++;
    if (r_reads != 0 || r_req_rise_n != -1) begin
      fails++; $display("FAIL replace_noread: reads %0d rise %0d want 0 / -1", r_reads, r_req_rise_n);
    end
    tests++;
    if (r_color !== 24'h123456) begin fails++; $display("FAIL replace_color: got %h want 123456", r_color); end
    tests++;
    if (r_write_n != 2) begin fails++; $display("FAIL replace_latency: write_o at %0d want 2", r_write_n); end
    tests++;
    if ({r_x, r_y, r_z} !== {16'd3, 16'd2, 16'hFFFB}) begin
      fails++; $display("FAIL replace_xyz: got %h %h %h want 0003 0002 fffb", r_x, r_y, r_z);
    end
    // ack_i answers write_o in its first cycle; ack_o follows once that ack has been taken.
    tests++;
    if (r_ack_n - r_write_n != 2 || r_acks != 1 || r_writes != 1) begin
      fails++; $display("FAIL replace_ack: gap %0d acks %0d writes %0d want 2 1 1",
                        r_ack_n - r_write_n, r_acks, r_writes);
    end
    $display("[TB] replace: color %h write@%0d ack@%0d", r_color, r_write_n, r_ack_n);
  endtask

  task automatic test_alpha_blend();
    run_fragment(2'd1, 8'd128, 8'd255, 24'hC8C8C8, 16'd10, 16'd5, 16'd7, 24'h646464, 0, 0, 1'b0);
    tests++;
    if (r_timeout) begin fails++; $display("FAIL alpha_timeout: no ack_o within budget"); end
    tests++;
    if (r_reads != 1) begin fails++; $display("FAIL alpha_reads: got %0d want 1", r_reads); end
    tests++;
    if (r_addr !== 32'h1000_3228) begin fails++; $display("FAIL alpha_addr: got %h want 10003228", r_addr); end
    tests++;
    if (r_color !== 24'h969696) begin fails++; $display("FAIL alpha_color: got %h want 969696", r_color); end
    tests++;
    if (r_req_after_ack != 0 || r_writes != 1 || r_acks != 1) begin
      fails++; $display("FAIL alpha_proto: req_after_ack %0d writes %0d acks %0d want 0 1 1",
                        r_req_after_ack, r_writes, r_acks);
    end
    $display("[TB] alpha: color %h addr %h", r_color, r_addr);
  endtask

  task automatic test_alpha_zero();
    run_fragment(2'd1, 8'd0, 8'd255, 24'hABCDEF, 16'd1, 16'd1, 16'd1, 24'h0, 0, 0, 1'b0);
    tests++;
    if (r_timeout) begin fails++; $display("FAIL azero_timeout: no ack_o within budget"); end
    tests++;
    if (r_req_rise_n != -1 || r_writes != 0) begin
      fails++; $display("FAIL azero_drop: rise %0d writes %0d want -1 0", r_req_rise_n, r_writes);
    end
    tests++;
    if (r_ack_n != 2 || r_acks != 1) begin
      fails++; $display("FAIL azero_ack: ack@%0d count %0d want 2 1", r_ack_n, r_acks);
    end
    $display("[TB] alpha zero: ack@%0d writes %0d", r_ack_n, r_writes);
  endtask

  task automatic test_alpha_opaque();
    run_fragment(2'd1, 8'd255, 8'd255, 24'hA1B2C3, 16'd4, 16'd4, 16'd4, 24'h0, 0, 0, 1'b0);
    tests++;
    if (r_timeout) begin fails++; $display("FAIL opaque_timeout: no ack_o within budget"); end
    tests++;
    if (r_req_rise_n != -1 || r_reads != 0) begin
      fails++; $display("FAIL opaque_noread: rise %0d reads %0d want -1 0", r_req_rise_n, r_reads);
    end
    tests++;
    if (r_color !== 24'hA1B2C3 || r_write_n != 2) begin
      fails++; $display("FAIL opaque_write: color %h at %0d want a1b2c3 at 2", r_color, r_write_n);
    end
    $display("[TB] alpha opaque: color %h", r_color);
  endtask

  task automatic test_add();
    run_fragment(2'd2, 8'd255, 8'd255, 24'hC80A50, 16'd6, 16'd9, 16'd2, 24'h641430, 0, 0, 1'b0);
    tests++;
    if (r_timeout) begin fails++; $display("FAIL add_timeout: no ack_o within budget"); end
    tests++;
    if (r_color !== 24'hFF1E80) begin fails++; $display("FAIL add_color: got %h want ff1e80", r_color); end
    tests++;
    if (r_reads != 1) begin fails++; $display("FAIL add_reads: got %0d want 1", r_reads); end
    $display("[TB] add: color %h", r_color);
  endtask

  // Zero alpha must not drop a multiply fragment; write_i is also held through the ack_o cycle.
  task automatic test_multiply();
    run_fragment(2'd3, 8'd0, 8'd255, 24'hFF8000, 16'd8, 16'd3, 16'd5, 24'h4DC863, 0, 0, 1'b1);
    tests++;
    if (r_timeout) begin fails++; $display("FAIL mul_timeout: no ack_o within budget"); end
    tests++;
    if (r_color !== 24'h4D6500) begin fails++; $display("FAIL mul_color: got %h want 4d6500", r_color); end
    tests++;
    if (r_reads != 1 || r_req_after_ack != 0 || r_acks != 1 || r_writes != 1) begin
      fails++; $display("FAIL mul_reaccept: reads %0d req_after %0d acks %0d writes %0d want 1 0 1 1",
                        r_reads, r_req_after_ack, r_acks, r_writes);
    end
    $display("[TB] multiply: color %h", r_color);
  endtask

  task automatic test_busy();
    run_fragment(2'd1, 8'd128, 8'd255, 24'hC8C8C8, 16'd10, 16'd5, 16'd7, 24'h646464, 5, 3, 1'b0);
    tests++;
    if (r_timeout) begin fails++; $display("FAIL busy_timeout: no ack_o within budget"); end
    tests++;
    if (r_req_busy != 0 || r_req_rise_n != 7) begin
      fails++; $display("FAIL busy_rise: req_while_busy %0d rise %0d want 0 7", r_req_busy, r_req_rise_n);
    end
    tests++;
    if (r_req_drop != 0 || r_req_after_ack != 0) begin
      fails++; $display("FAIL busy_hold: drops %0d after_ack %0d want 0 0", r_req_drop, r_req_after_ack);
    end
    tests++;
    if (r_color !== 24'h969696) begin fails++; $display("FAIL busy_color: got %h want 969696", r_color); end
    $display("[TB] busy: request rose at %0d color %h", r_req_rise_n, r_color);
  endtask

  task automatic test_reset_mid_read();
    int act;
    @(negedge clk_i);
    mode_i = 2'd1; alpha_i = 8'd128; global_alpha_i = 8'd255; color_i = 24'h777777;
    x_i = 16'd2; y_i = 16'd2; z_i = 16'd2; wbm_busy_i = 1'b0; write_i = 1'b1;
    for (int k = 0; k < 20 && !target_request_o; k++) begin
      @(posedge clk_i); #1;
    end
    tests++;
    if (!target_request_o) begin fails++; $display("FAIL rstmid_request: got 0 want 1 before reset"); end
    #3;
    rst_ni = 1'b0;
    #1;
    write_i = 1'b0;
    tests++;
    if ({target_request_o, write_o, ack_o} !== 3'b000 || target_addr_o !== 32'h0) begin
      fails++; $display("FAIL rstmid_ctrl: ctrl %b addr %h want 000 0",
                        {target_request_o, write_o, ack_o}, target_addr_o);
    end
    tests++;
    if (pixel_color_o !== 24'h0 || {pixel_x_o, pixel_y_o, pixel_z_o} !== 48'h0) begin
      fails++; $display("FAIL rstmid_pixel: color %h xyz %h want 0", pixel_color_o,
                        {pixel_x_o, pixel_y_o, pixel_z_o});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    target_ack_i = 1'b1;
    target_data_i = 24'h010101;
    @(negedge clk_i);
    target_ack_i = 1'b0;
    act = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_i); #1;
      if (write_o || ack_o || target_request_o) act++;
    end
    tests++;
    if (act != 0) begin fails++; $display("FAIL rstmid_stale: activity %0d want 0", act); end
    run_fragment(2'd1, 8'd128, 8'd255, 24'h102030, 16'd1, 16'd1, 16'd3, 24'h4080C0, 0, 0, 1'b0);
    tests++;
    if (r_timeout || r_acks != 1) begin
      fails++; $display("FAIL rstmid_next_ack: timeout %0d acks %0d want 0 1", r_timeout, r_acks);
    end
    tests++;
    if (r_color !== 24'h285077 || r_addr !== 32'h1000_0A04) begin
      fails++; $display("FAIL rstmid_next: color %h addr %h want 285077 10000a04", r_color, r_addr);
    end
    $display("[TB] reset mid-read: next fragment color %h", r_color);
  endtask

  initial begin
    test_reset();
    test_replace();
    test_alpha_blend();
    test_alpha_zero();
    test_alpha_opaque();
    test_add();
    test_multiply();
    test_busy();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gfx_blender_multi.md
Name: gfx_blender_multi

Overview:
- Parametrised next-generation per-pixel blender for the gfx accelerator pipeline.
- Sits between the fragment stage and the render stage; reads the target pixel through the wishbone reader arbiter only when needed.
- Handles CH channels of CW bits each.
- Four blend modes: replace, alpha, additive-saturating, multiply.
- Fast paths: fully transparent pixels are dropped (no write); opaque replace-equivalent pixels skip the target read.

Parameters:
- PW, 16: point (x/y/z) width.
- CW, 8: bits per colour channel.
- CH, 3: channel count; packed colour width is CH*CW, channel 0 in the LSBs.
- BPP, 4: bytes per target pixel, used in address calculation.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mode_i  in  2  0 replace, 1 alpha, 2 add, 3 multiply.
- target_base_i  in  32  byte base address of target surface.
- target_size_x_i  in  PW  target width in pixels.
- global_alpha_i  in  8  global alpha.
- x_i, y_i  in  PW each  fragment coordinates.
- z_i  in  PW  fragment depth (signed).
- alpha_i  in  8  fragment alpha.
- color_i  in  CH*CW  source colour.
- write_i  in  1  fragment valid; held high until ack_o.
- ack_o  out  1  one-cycle completion pulse.
- target_request_o  out  1  read request to wbm reader.
- target_addr_o  out  32  byte address of target pixel.
- target_data_i  in  CH*CW  target colour, valid with target_ack_i.
- target_ack_i  in  1  read done.
- wbm_busy_i  in  1  reader arbiter busy.
- pixel_x_o, pixel_y_o, pixel_z_o  out  PW each  to render.
- pixel_color_o  out  CH*CW  blended colour.
- write_o  out  1  write request to render.
- ack_i  in  1  render done.

Behaviour:
- Reset (async, rst_ni low): state=IDLE. Outputs cleared: ack_o, target_request_o, write_o, pixel_*_o, pixel_color_o, target_addr_o.
- IDLE: when write_i=1 (and ack_o=0), latch mode, coords, z, colour, and product p=alpha_i*global_alpha_i (16-bit) into registers → state ALPHA. All later stages use only latched values.
- ALPHA (1 cycle):
  - Compute a=(p+(p>>8)+128)>>8 (8-bit; 255*255→255, 0→0) and a'=a+a[7] (9-bit, 0..256).
  - Register target_addr_o = target_base_i + (y*target_size_x_i + x)*BPP, truncated to 32 bits.
  - Next state: if mode=1 and a=0 → DONE (no write). If mode=0, or mode=1 and a=255 → WRITE with pixel_color_o=source. Otherwise → READ.
- READ:
  - target_request_o <= !wbm_busy_i | target_request_o; once high, it holds until target_ack_i.
  - On target_ack_i: drop the request, latch target_data_i as d → BLEND.
- BLEND (1 cycle), per channel, with s=source and d=target:
  - mode 1: (s*a' + d*(256-a') + 128)>>8.
  - mode 2: min(d + ((s*a'+128)>>8), 2^CW-1).
  - mode 3: s'=s+s[CW-1]; (s'*d + 2^(CW-1))>>CW.
  - Results are registered into pixel_color_o → WRITE.
- WRITE: drive pixel_x/y/z_o from the latched values, write_o=1 → WACK.
- WACK: write_o <= 0. On ack_i → DONE. If ack_i arrives in the same cycle write_o is first high, it is still honoured.
- DONE: ack_o=1 for exactly one cycle → IDLE. A fragment still asserting write_i in that cycle is not re-accepted; acceptance requires ack_o=0.
- Latency, no stalls: replace 3 cycles from accept to write_o; blended modes 4 cycles plus read wait.
- Arithmetic uses full-width intermediates (CW+9 bits); no overflow is permitted before the shift.
- write_i dropping mid-operation has no effect; the latched pixel completes.
- Reset mid-operation aborts immediately; a pending read ack after reset is ignored.

Test Plan:
- mode 0, colour 0x123456, alpha_i 0 → no read. write_o with color 0x123456 at cycle 3 after accept. ack_o one cycle after ack_i.
- mode 1, alpha_i 128, global 255, s=200 all channels, d=100 → a=128, a'=129. Output 150 per channel. One target read at base+(y*w+x)*4.
- mode 1, alpha_i 0 → no request, no write_o. ack_o pulses 3 cycles after accept.
- mode 1, alpha 255, global 255 → a=255, no read, output=source.
- mode 2, s=200, d=100, a=255 → saturates to 255. mode 3, s=255, d=77 → 77. mode 3, s=128, d=200 → 101.
- wbm_busy_i held 5 cycles in READ → request rises only after busy clears, then stays high until target_ack_i. Assert rst_ni low during READ → all outputs 0 asynchronously; next fragment processed normally.
